countdown_ctrl: RTL
===================

// Module: countdown_ctrl
// PURPOSE
//  Control front-end that drives the countdown timer's set/new_sec inputs and watches its cur_sec output.
//  - Takes raw push-buttons (up/down/start/stop); synchronises and debounces each.
//  - Holds the user's start value (0..MAX_SEC) and sequences SETUP -> RUN -> EXPIRED.
//  - Flags expiry when cur_sec reaches 0.
//  - Sits between board buttons and the timer; status outputs feed the 7-seg/LED logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable clk cycles before a button level is accepted (10 ms @ 25 MHz)
//  DEFAULT_SEC      4       start value loaded at reset (0..MAX_SEC)
//  MAX_SEC          9       upper saturation limit of the start value (<=15)
// PORTS
//  clk        in   1  25 MHz system clock
//  rst_n      in   1  asynchronous reset, active-low
//  btn_up     in   1  raw button, async to clk, active-high: increment start value
//  btn_down   in   1  raw button, async to clk, active-high: decrement start value
//  btn_start  in   1  raw button, async to clk, active-high: begin countdown / re-arm after expiry
//  btn_stop   in   1  raw button, async to clk, active-high: abort countdown, return to SETUP
//  cur_sec    in   4  current seconds reported by the timer
//  set        out  1  to timer: 1 = load new_sec, hold; 0 = count down
//  new_sec    out  4  to timer: start value (= setting register)
//  running    out  1  1 while in RUN
//  expired    out  1  1 while in EXPIRED
//  timeout    out  1  one-cycle pulse on entry to EXPIRED
// BEHAVIOUR
//  Reset (rst_n=0, async): state=SETUP, set=1, new_sec=DEFAULT_SEC, running=0, expired=0, timeout=0.
//    Sync flops and debounce counters are 0; debounced levels are 0.
//  Input conditioning, per button:
//  - 2-flop synchroniser.
//  - Debounce counter: counts while sync value != debounced level; clears when they match.
//  - At DEBOUNCE_CYCLES the debounced level takes the sync value and the counter clears.
//  - press = registered 0->1 edge of debounced level, exactly one cycle wide; release edges ignored.
//  FSM (state registered; all outputs are registered decodes of state/setting):
//  - SETUP: set=1.
//    - up_press: setting+1, saturates at MAX_SEC. down_press: setting-1, saturates at 0.
//    - up and down in same cycle: no change.
//    - start_press -> RUN. new_sec reflects setting 1 cycle after the press.
//  - RUN: set=0, running=1; setting frozen (up/down ignored).
//    - Priority stop > expiry > start.
//    - stop_press -> SETUP. set=1 next cycle, reloading the timer with the unchanged setting.
//    - cur_sec==0 -> EXPIRED; timeout=1 for that one transition cycle.
//    - start_press ignored.
//    - Setting 0 at start: expiry detected on the first RUN cycle; timer already holds 0.
//  - EXPIRED: set=0, expired=1; up/down ignored.
//    - start_press or stop_press -> SETUP; setting retained.
//  Any state, rst_n low: immediate return to reset values, including mid-RUN and mid-debounce.
//  setting is 4 bits. MAX_SEC > 15 or DEFAULT_SEC > MAX_SEC is illegal; an elaboration-time check is required.
// TESTING (bench uses DEBOUNCE_CYCLES=4; cur_sec driven by a behavioural timer model)
//  1 Reset release -> set=1, new_sec=4, running=0, expired=0, timeout=0.
//    up pulse held 10 cycles -> new_sec=5 exactly 2+4+2 cycles after the edge.
//  2 Seven clean up presses from 4 -> new_sec saturates at 9.
//    Twelve down presses -> saturates at 0; up+down together -> no change.
//  3 Bounce: btn_up toggles every 2 cycles for 20 cycles, then low.
//    -> new_sec unchanged, no press generated.
//  4 Setting 3, start -> set=0, running=1. Model counts 3,2,1,0.
//    -> timeout single-cycle pulse the cycle cur_sec==0 is seen; expired=1, set=0.
//    start -> SETUP, new_sec=3.
//  5 Mid-RUN at cur_sec=2: stop and up pressed together.
//    -> SETUP, set=1, new_sec=3 (unchanged), no timeout.
//    start+stop together in RUN -> stop wins.
//  6 Setting 0, start -> EXPIRED on first RUN cycle with one timeout pulse.
//    rst_n low mid-RUN -> all outputs back to reset values asynchronously.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Control front-end for the countdown timer: conditions four raw push-buttons,
// holds the user's start value and sequences SETUP -> RUN -> EXPIRED.
module countdown_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEFAULT_SEC     = 4,
  parameter int MAX_SEC         = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic [3:0] cur_sec,
  output logic       set,
  output logic [3:0] new_sec,
  output logic       running,
  output logic       expired,
  output logic       timeout
);

  if (MAX_SEC > 15 || MAX_SEC < 0 || DEFAULT_SEC > MAX_SEC || DEFAULT_SEC < 0 ||
      DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("countdown_ctrl: illegal MAX_SEC/DEFAULT_SEC/DEBOUNCE_CYCLES");
  end

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]        MAX_VAL  = 4'(MAX_SEC);
  localparam logic [3:0]        DEF_VAL  = 4'(DEFAULT_SEC);

  // Button bit order: 0 = up, 1 = down, 2 = start, 3 = stop
  logic [3:0]       btn_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       db_r;
  logic [3:0]       db_d_r;
  logic [3:0]       press_r;
  logic [CNT_W-1:0] cnt_r [4];

  assign btn_s = {btn_stop, btn_start, btn_down, btn_up};

  // Synchronise, debounce and edge-detect every button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      db_r    <= 4'b0000;
      db_d_r  <= 4'b0000;
      press_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      press_r <= db_r & ~db_d_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  typedef enum logic [1:0] {
    ST_SETUP   = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] setting_r;
  logic       set_r;
  logic       running_r;
  logic       expired_r;
  logic       timeout_r;

  logic up_press_s;
  logic down_press_s;
  logic start_press_s;
  logic stop_press_s;

  assign up_press_s    = press_r[0];
  assign down_press_s  = press_r[1];
  assign start_press_s = press_r[2];
  assign stop_press_s  = press_r[3];

  // Sequencer; outputs are updated together with the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_SETUP;
      setting_r <= DEF_VAL;
      set_r     <= 1'b1;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_SETUP: begin
          if (up_press_s && !down_press_s && setting_r != MAX_VAL) begin
            setting_r <= setting_r + 4'd1;
          end else if (down_press_s && !up_press_s && setting_r != 4'd0) begin
            setting_r <= setting_r - 4'd1;
          end else begin
            setting_r <= setting_r;
          end
          if (start_press_s) begin
            state_r   <= ST_RUN;
            set_r     <= 1'b0;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_SETUP;
          end
        end
        ST_RUN: begin
          // Stop outranks expiry, so a late stop never produces a timeout
          if (stop_press_s) begin
            state_r   <= ST_SETUP;
            set_r     <= 1'b1;
            running_r <= 1'b0;
          end else if (cur_sec == 4'd0) begin
            state_r   <= ST_EXPIRED;
            running_r <= 1'b0;
            expired_r <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            state_r   <= ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (start_press_s || stop_press_s) begin
            state_r   <= ST_SETUP;
            set_r     <= 1'b1;
            expired_r <= 1'b0;
          end else begin
            state_r   <= ST_EXPIRED;
          end
        end
        default: begin
          state_r   <= ST_SETUP;
          set_r     <= 1'b1;
          running_r <= 1'b0;
          expired_r <= 1'b0;
        end
      endcase
    end
  end

  assign set     = set_r;
  assign new_sec = setting_r;
  assign running = running_r;
  assign expired = expired_r;
  assign timeout = timeout_r;

endmodule
